// File: rtl/knn_dist_pipe_if.sv
// rtl/knn_dist_pipe_if.sv - point input stream and distance record output stream of knn_dist_pipe
interface knn_dist_pipe_if #(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 8,
  parameter int LABEL_W = 4
);
  localparam int DIST_W = 2 * DATA_W + 1;

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_x;
  logic [DATA_W-1:0]  in_y;
  logic [LABEL_W-1:0] in_label;

  logic               out_valid;
  logic               out_ready;
  logic [DIST_W-1:0]  out_dist;
  logic [IDX_W-1:0]   out_idx;
  logic [LABEL_W-1:0] out_label;
  logic               out_last;

  modport slave (
    input  in_valid, in_x, in_y, in_label, out_ready,
    output in_ready, out_valid, out_dist, out_idx, out_label, out_last
  );

  modport master (
    output in_valid, in_x, in_y, in_label, out_ready,
    input  in_ready, out_valid, out_dist, out_idx, out_label, out_last
  );
endinterface

// File: rtl/knn_dist_pipe.sv
// rtl/knn_dist_pipe.sv - squared-Euclidean distance stage feeding the KNN sorter
// Three register stages (diff, square, sum) with collapsing bubbles and valid/ready on both sides.
module knn_dist_pipe #(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 8,
  parameter int LABEL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] test_x_i,
  input  logic [DATA_W-1:0] test_y_i,
  input  logic [IDX_W-1:0]  n_points_i,
  output logic              busy_o,
  output logic              done_o,
  knn_dist_pipe_if.slave    bus
);
  localparam int DIFF_W = DATA_W + 1;
  localparam int SQ_W   = 2 * DATA_W;
  localparam int DIST_W = 2 * DATA_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   cnt_q, n_q;
  logic [DATA_W-1:0]  tx_q, ty_q;
  logic               busy_q, done_q;

  logic                     s1_v_q, s2_v_q, s3_v_q;
  logic signed [DIFF_W-1:0] s1_dx_q, s1_dy_q;
  logic [SQ_W-1:0]          s2_sx_q, s2_sy_q;
  logic [DIST_W-1:0]        s3_dist_q;
  logic [IDX_W-1:0]         s1_idx_q, s2_idx_q, s3_idx_q;
  logic [LABEL_W-1:0]       s1_label_q, s2_label_q, s3_label_q;
  logic                     s1_last_q, s2_last_q, s3_last_q;

  logic                     adv1, adv2, adv3, accept, out_hs;
  logic signed [DIFF_W-1:0] dx_d, dy_d;
  logic [SQ_W-1:0]          sx_d, sy_d;
  logic [DIST_W-1:0]        dist_d;
  logic                     last_d;

  // |d| of a (DATA_W+1)-bit difference always fits DATA_W unsigned bits, so the square is exact in 2*DATA_W.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DIFF_W-1:0] d);
    mag = d[DIFF_W-1] ? DATA_W'(-d) : d[DATA_W-1:0];
  endfunction

  assign adv3   = !s3_v_q || bus.out_ready;
  assign adv2   = !s2_v_q || adv3;
  assign adv1   = !s1_v_q || adv2;
  assign bus.in_ready = (state_q == RUN) && (cnt_q < n_q) && adv1;
  assign accept = bus.in_valid && bus.in_ready;
  assign out_hs = s3_v_q && bus.out_ready;

  assign dx_d   = $signed({bus.in_x[DATA_W-1], bus.in_x}) - $signed({tx_q[DATA_W-1], tx_q});
  assign dy_d   = $signed({bus.in_y[DATA_W-1], bus.in_y}) - $signed({ty_q[DATA_W-1], ty_q});
  assign last_d = (cnt_q == n_q - IDX_W'(1));
  assign sx_d   = SQ_W'(mag(s1_dx_q)) * SQ_W'(mag(s1_dx_q));
  assign sy_d   = SQ_W'(mag(s1_dy_q)) * SQ_W'(mag(s1_dy_q));
  assign dist_d = {1'b0, s2_sx_q} + {1'b0, s2_sy_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start_i) begin
          tx_q   <= test_x_i;
          ty_q   <= test_y_i;
          n_q    <= n_points_i;
          cnt_q  <= '0;
          busy_q <= 1'b1;
          if (n_points_i == '0) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: if (accept) begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q + IDX_W'(1) == n_q) state_q <= DRAIN;
        end
        DRAIN: if (out_hs && s3_last_q) begin
          state_q <= FIN;
          done_q  <= 1'b1;
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      s3_dist_q  <= '0;
      s3_idx_q   <= '0;
      s3_label_q <= '0;
      s3_last_q  <= 1'b0;
    end else begin
      if (adv1) s1_v_q <= accept;
      if (adv2) s2_v_q <= s1_v_q;
      if (adv3) s3_v_q <= s2_v_q;
      if (adv3 && s2_v_q) begin
        s3_dist_q  <= dist_d;
        s3_idx_q   <= s2_idx_q;
        s3_label_q <= s2_label_q;
        s3_last_q  <= s2_last_q;
      end
    end
  end

  // In-flight data only matters when the matching valid bit is set, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_dx_q    <= dx_d;
      s1_dy_q    <= dy_d;
      s1_idx_q   <= cnt_q;
      s1_label_q <= bus.in_label;
      s1_last_q  <= last_d;
    end
    if (adv2 && s1_v_q) begin
      s2_sx_q    <= sx_d;
      s2_sy_q    <= sy_d;
      s2_idx_q   <= s1_idx_q;
      s2_label_q <= s1_label_q;
      s2_last_q  <= s1_last_q;
    end
  end

  assign bus.out_valid = s3_v_q;
  assign bus.out_dist  = s3_dist_q;
  assign bus.out_idx   = s3_idx_q;
  assign bus.out_label = s3_label_q;
  assign bus.out_last  = s3_last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
endmodule

// File: tb/tb_knn_dist_pipe.sv
// tb/tb_knn_dist_pipe.sv - self-checking bench for knn_dist_pipe
// Scenario tasks compare captured records against an integer-arithmetic distance model.
module tb_knn_dist_pipe;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 8;
  localparam int LABEL_W = 4;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic [15:0] test_x, test_y;
  logic [7:0]  n_points;

  knn_dist_pipe_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .LABEL_W(LABEL_W)) bus ();

  knn_dist_pipe #(.DATA_W(DATA_W), .IDX_W(IDX_W), .LABEL_W(LABEL_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .test_x_i(test_x), .test_y_i(test_y), .n_points_i(n_points),
    .busy_o(busy), .done_o(done), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks, failures;
  int px[256], py[256], pl[256];
  longint got_dist[$];
  int got_idx[$], got_label[$], got_last[$];
  int first_acc_cyc, first_out_cyc, last_hs_cyc, done_cyc, done_cnt, ovalid_cnt, stall_changes, full_blocks;

  function automatic longint ref_dist(input int tx, input int ty, input int x, input int y);
    longint dx, dy;
    dx = longint'(x) - longint'(tx);
    dy = longint'(y) - longint'(ty);
    return dx * dx + dy * dy;
  endfunction

  function automatic int rand_coord();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      px[i] = rand_coord();
      py[i] = rand_coord();
      pl[i] = int'($urandom_range(0, 15));
    end
  endtask

  // vmode 0: in_valid whenever points remain, 1: random gaps.
  // rmode 0: out_ready=1, 1: pattern 1,0,0 repeating, 2: random.
  task automatic run_stream(input int tx, input int ty, input int n, input int vmode, input int rmode,
                            input int restart_cyc);
    int sent;
    bit held;
    logic [32:0] h_dist;
    logic [7:0]  h_idx;
    logic [3:0]  h_label;
    logic        h_last;
    got_dist.delete(); got_idx.delete(); got_label.delete(); got_last.delete();
    first_acc_cyc = -1; first_out_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    done_cnt = 0; ovalid_cnt = 0; stall_changes = 0; full_blocks = 0;
    sent = 0; held = 0;
    h_dist = '0; h_idx = '0; h_label = '0; h_last = 1'b0;
    for (int cyc = 0; cyc < 20 * n + 60; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == restart_cyc);
      if (cyc == 0) begin
        test_x = 16'(tx); test_y = 16'(ty); n_points = 8'(n);
      end else if (cyc == restart_cyc) begin
        test_x = 16'(tx + 100); test_y = 16'(ty - 7); n_points = 8'(n + 3);
      end else begin
        test_x = 16'($urandom); test_y = 16'($urandom); n_points = 8'($urandom);
      end
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (sent < n && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
        bus.in_valid = 1'b1;
        bus.in_x = 16'(px[sent]); bus.in_y = 16'(py[sent]); bus.in_label = 4'(pl[sent]);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_x = 16'($urandom); bus.in_y = 16'($urandom); bus.in_label = 4'($urandom);
      end
      #1;
      if (bus.in_valid && bus.in_ready) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        sent++;
      end else if (bus.in_valid && busy) begin
        full_blocks++;
      end
      if (held && (!bus.out_valid || bus.out_dist !== h_dist || bus.out_idx !== h_idx ||
                   bus.out_label !== h_label || bus.out_last !== h_last))
        stall_changes++;
      if (bus.out_valid) begin
        ovalid_cnt++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        if (bus.out_ready) begin
          got_dist.push_back(longint'(bus.out_dist));
          got_idx.push_back(int'(bus.out_idx));
          got_label.push_back(int'(bus.out_label));
          got_last.push_back(int'(bus.out_last));
          if (bus.out_last) last_hs_cyc = cyc;
        end
      end
      held = bus.out_valid && !bus.out_ready;
      h_dist = bus.out_dist; h_idx = bus.out_idx; h_label = bus.out_label; h_last = bus.out_last;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_dist !== 33'd0 || bus.out_idx !== 8'd0 || bus.out_label !== 4'd0 || bus.out_last !== 1'b0) begin
      failures++; $display("FAIL reset_out_fields got=%0d/%0d/%0d/%0b exp=0/0/0/0", bus.out_dist, bus.out_idx, bus.out_label, bus.out_last);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic();
    longint exp_d[3] = '{25, 2, 4};
    px[0] = 3;  py[0] = 4; pl[0] = 5;
    px[1] = 1;  py[1] = 1; pl[1] = 9;
    px[2] = -2; py[2] = 0; pl[2] = 2;
    run_stream(0, 0, 3, 0, 0, -1);
    checks++; if (got_dist.size() != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", got_dist.size()); end
    for (int i = 0; i < 3 && i < got_dist.size(); i++) begin
      checks++;
      if (got_dist[i] !== exp_d[i] || got_idx[i] !== i || got_label[i] !== pl[i] || got_last[i] !== int'(i == 2)) begin
        failures++;
        $display("FAIL basic_rec%0d got=(%0d,%0d,%0d,%0d) exp=(%0d,%0d,%0d,%0d)", i, got_dist[i], got_idx[i],
                 got_label[i], got_last[i], exp_d[i], i, pl[i], int'(i == 2));
      end
    end
    checks++; if (first_out_cyc - first_acc_cyc != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", first_out_cyc - first_acc_cyc); end
    checks++; if (done_cyc - last_hs_cyc != 1) begin failures++; $display("FAIL basic_done_delay got=%0d exp=1", done_cyc - last_hs_cyc); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_extremes();
    px[0] = 32767;  py[0] = 32767;  pl[0] = 15;
    px[1] = -32768; py[1] = -32768; pl[1] = 0;
    run_stream(-32768, -32768, 2, 0, 0, -1);
    checks++; if (got_dist.size() != 2) begin failures++; $display("FAIL ext_count got=%0d exp=2", got_dist.size()); end
    if (got_dist.size() >= 2) begin
      checks++; if (got_dist[0] !== 64'd8589672450) begin failures++; $display("FAIL ext_max_dist got=%0d exp=8589672450", got_dist[0]); end
      checks++; if (got_dist[1] !== 64'd0 || got_last[1] !== 1) begin failures++; $display("FAIL ext_zero_dist got=%0d/%0d exp=0/1", got_dist[1], got_last[1]); end
    end
  endtask

  task automatic test_backpressure();
    int tx, ty;
    tx = rand_coord(); ty = rand_coord();
    fill_random(8);
    run_stream(tx, ty, 8, 0, 1, -1);
    checks++; if (got_dist.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got_dist.size()); end
    for (int i = 0; i < 8 && i < got_dist.size(); i++) begin
      checks++;
      if (got_dist[i] !== ref_dist(tx, ty, px[i], py[i]) || got_idx[i] !== i || got_label[i] !== pl[i] || got_last[i] !== int'(i == 7)) begin
        failures++;
        $display("FAIL bp_rec%0d got=(%0d,%0d,%0d,%0d) exp=(%0d,%0d,%0d,%0d)", i, got_dist[i], got_idx[i], got_label[i],
                 got_last[i], ref_dist(tx, ty, px[i], py[i]), i, pl[i], int'(i == 7));
      end
    end
    checks++; if (stall_changes != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stall_changes); end
    checks++; if (full_blocks == 0) begin failures++; $display("FAIL bp_in_ready_drop got=%0d exp=>0", full_blocks); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_zero_start();
    run_stream(5, 5, 0, 0, 0, -1);
    checks++; if (done_cyc != 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cyc); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
    checks++; if (ovalid_cnt != 0) begin failures++; $display("FAIL zero_out_valid got=%0d exp=0", ovalid_cnt); end
  endtask

  task automatic test_ignored_start();
    int tx, ty;
    tx = rand_coord(); ty = rand_coord();
    fill_random(6);
    run_stream(tx, ty, 6, 0, 0, 3);
    checks++; if (got_dist.size() != 6) begin failures++; $display("FAIL ign_count got=%0d exp=6", got_dist.size()); end
    for (int i = 0; i < 6 && i < got_dist.size(); i++) begin
      checks++;
      if (got_dist[i] !== ref_dist(tx, ty, px[i], py[i]) || got_idx[i] !== i || got_last[i] !== int'(i == 5)) begin
        failures++;
        $display("FAIL ign_rec%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", i, got_dist[i], got_idx[i], got_last[i],
                 ref_dist(tx, ty, px[i], py[i]), i, int'(i == 5));
      end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid_run();
    int k, spurious, tx, ty;
    fill_random(5);
    @(negedge clk);
    start = 1'b1; test_x = 16'd10; test_y = 16'hFFFD; n_points = 8'd5;
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_x = 16'(px[k]); bus.in_y = 16'(py[k]); bus.in_label = 4'(pl[k]);
      #1;
      if (bus.in_ready) k++;
    end
    checks++; if (k != 2) begin failures++; $display("FAIL rst_accepts got=%0d exp=2", k); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_in_ready got=%0b exp=0", bus.in_ready); end
    spurious = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      if (done || bus.out_valid) spurious++;
    end
    checks++; if (spurious != 0) begin failures++; $display("FAIL rst_mid_spurious got=%0d exp=0", spurious); end
    tx = rand_coord(); ty = rand_coord();
    fill_random(3);
    run_stream(tx, ty, 3, 0, 0, -1);
    checks++; if (got_dist.size() != 3) begin failures++; $display("FAIL rst_fresh_count got=%0d exp=3", got_dist.size()); end
    for (int i = 0; i < 3 && i < got_dist.size(); i++) begin
      checks++;
      if (got_dist[i] !== ref_dist(tx, ty, px[i], py[i]) || got_idx[i] !== i || got_last[i] !== int'(i == 2)) begin
        failures++;
        $display("FAIL rst_fresh_rec%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", i, got_dist[i], got_idx[i], got_last[i],
                 ref_dist(tx, ty, px[i], py[i]), i, int'(i == 2));
      end
    end
  endtask

  task automatic test_random();
    int n, tx, ty;
    for (int r = 0; r < 6; r++) begin
      n = (r == 5) ? 255 : int'($urandom_range(1, 40));
      tx = rand_coord(); ty = rand_coord();
      fill_random(n);
      run_stream(tx, ty, n, 1, 2, -1);
      checks++; if (got_dist.size() != n) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, got_dist.size(), n); end
      for (int i = 0; i < n && i < got_dist.size(); i++) begin
        checks++;
        if (got_dist[i] !== ref_dist(tx, ty, px[i], py[i]) || got_idx[i] !== i || got_label[i] !== pl[i] ||
            got_last[i] !== int'(i == n - 1)) begin
          failures++;
          $display("FAIL rand%0d_rec%0d got=(%0d,%0d,%0d,%0d) exp=(%0d,%0d,%0d,%0d)", r, i, got_dist[i], got_idx[i],
                   got_label[i], got_last[i], ref_dist(tx, ty, px[i], py[i]), i, pl[i], int'(i == n - 1));
        end
      end
      checks++; if (stall_changes != 0) begin failures++; $display("FAIL rand%0d_stable got=%0d exp=0", r, stall_changes); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL rand%0d_done_count got=%0d exp=1", r, done_cnt); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; test_x = '0; test_y = '0; n_points = '0;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_label = '0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_zero_start();
    test_ignored_start();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
